// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg_scan_ctrl                                                   |
// | Purpose  : Eight-digit multiplexed 7-segment scan controller with 16-level |
// |            brightness, per-digit mask, leading-zero blanking and          |
// |            frame-synchronous double-buffered data/dp registers.           |
// | Ports    : cpu_clk    - clock                                              |
// |            cpu_rst_n  - synchronous active-low reset                       |
// |            wr_en      - register write strobe                              |
// |            wr_sel     - 0=data 1=digit mask 2=config 3=dp                  |
// |            wdata      - write data                                         |
// |            dig_en     - active-low digit enables (one-hot-low or all ones) |
// |            seg        - active-low segments {dp,g,f,e,d,c,b,a}             |
// |            frame_tick - one-cycle pulse on the first cycle of each frame   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg_scan_ctrl #(
  parameter int PHASE_LEN = 1000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wdata,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int            c_CW      = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(PHASE_LEN - 1);

  localparam logic [1:0] c_SEL_DATA = 2'd0;
  localparam logic [1:0] c_SEL_MASK = 2'd1;
  localparam logic [1:0] c_SEL_CFG  = 2'd2;
  localparam logic [1:0] c_SEL_DP   = 2'd3;

  // Scan counters
  logic [c_CW-1:0] r_phase_cnt;
  logic [3:0]      r_phase;
  logic [2:0]      r_digit;

  // Register file
  logic [31:0] r_shadow_data;
  logic [31:0] r_active_data;
  logic [7:0]  r_shadow_dp;
  logic [7:0]  r_active_dp;
  logic [7:0]  r_mask;
  logic [3:0]  r_bright;
  logic        r_blank_lz;

  // Registered outputs
  logic [7:0] r_dig_en;
  logic [7:0] r_seg;
  logic       r_frame_tick;

  logic       w_cnt_wrap;
  logic       w_frame_end;
  logic       w_frame_start;
  logic [7:0] w_hi_zero;
  logic       w_blank;
  logic       w_lit;
  logic [3:0] w_nibble;
  logic [6:0] w_pattern;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] f_hex(input logic [3:0] n);
    case (n)
      4'h0:    f_hex = 7'h40;
      4'h1:    f_hex = 7'h79;
      4'h2:    f_hex = 7'h24;
      4'h3:    f_hex = 7'h30;
      4'h4:    f_hex = 7'h19;
      4'h5:    f_hex = 7'h12;
      4'h6:    f_hex = 7'h02;
      4'h7:    f_hex = 7'h78;
      4'h8:    f_hex = 7'h00;
      4'h9:    f_hex = 7'h10;
      4'hA:    f_hex = 7'h08;
      4'hB:    f_hex = 7'h03;
      4'hC:    f_hex = 7'h46;
      4'hD:    f_hex = 7'h21;
      4'hE:    f_hex = 7'h06;
      default: f_hex = 7'h0E;
    endcase
  endfunction

  assign w_cnt_wrap    = (r_phase_cnt == c_CNT_MAX);
  assign w_frame_end   = w_cnt_wrap && (r_phase == 4'hF) && (r_digit == 3'd7);
  assign w_frame_start = (r_phase_cnt == '0) && (r_phase == 4'h0) && (r_digit == 3'd0);

  // w_hi_zero[i]: nibbles i..7 of the displayed data are all zero.
  for (genvar i = 0; i < 8; i++) begin : g_hi_zero
    assign w_hi_zero[i] = (r_active_data[31:4*i] == '0);
  end

  assign w_blank   = r_blank_lz && (r_digit != 3'd0) && w_hi_zero[r_digit];
  assign w_lit     = r_mask[r_digit] && (r_phase <= r_bright) && !w_blank;
  assign w_nibble  = r_active_data[{r_digit, 2'b00} +: 4];
  assign w_pattern = f_hex(w_nibble);

  // Scan counters: phase_cnt -> phase -> digit, all wrapping naturally.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      r_phase_cnt <= '0;
      r_phase     <= 4'h0;
      r_digit     <= 3'd0;
    end else if (w_cnt_wrap) begin
      r_phase_cnt <= '0;
      r_phase     <= r_phase + 4'h1;
      if (r_phase == 4'hF) begin
        r_digit <= r_digit + 3'd1;
      end
    end else begin
      r_phase_cnt <= r_phase_cnt + 1'b1;
    end
  end

  // Bus writes. The commit reads the shadow's current value, so a write
  // landing on the boundary edge stays in the shadow for the next frame.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      r_shadow_data <= 32'h0;
      r_active_data <= 32'h0;
      r_shadow_dp   <= 8'h00;
      r_active_dp   <= 8'h00;
      r_mask        <= 8'hFF;
      r_bright      <= 4'hF;
      r_blank_lz    <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_sel)
          c_SEL_DATA: r_shadow_data <= wdata;
          c_SEL_MASK: r_mask        <= wdata[7:0];
          c_SEL_CFG: begin
            r_bright   <= wdata[3:0];
            r_blank_lz <= wdata[4];
          end
          c_SEL_DP:   r_shadow_dp   <= wdata[7:0];
          default: ;
        endcase
      end
      if (w_frame_end) begin
        r_active_data <= r_shadow_data;
        r_active_dp   <= r_shadow_dp;
      end
    end
  end

  // Output stage: one cycle behind the counter state it reflects.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      r_dig_en     <= 8'hFF;
      r_seg        <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_start;
      if (w_lit) begin
        r_dig_en <= ~(8'b1 << r_digit);
        r_seg    <= {~r_active_dp[r_digit], w_pattern};
      end else begin
        r_dig_en <= 8'hFF;
        r_seg    <= 8'hFF;
      end
    end
  end

  assign dig_en     = r_dig_en;
  assign seg        = r_seg;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seg_scan_ctrl                                                |
// | Purpose  : Self-checking bench for seg_scan_ctrl with PHASE_LEN=2          |
// |            (slot = 32 cycles, frame = 256 cycles).                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seg_scan_ctrl;

  localparam int PHASE_LEN = 2;
  localparam int FRAME     = 128 * PHASE_LEN;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [31:0] wdata;
  logic [7:0]  dig_en;
  logic [7:0]  seg;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(.PHASE_LEN(PHASE_LEN)) u_dut (
    .cpu_clk    (clk),
    .cpu_rst_n  (rst_n),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wdata      (wdata),
    .dig_en     (dig_en),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mask;
    logic [4:0]  cfg;     // {blank_lz, bright}
    logic [7:0]  dp;
    logic [31:0] data;
    int          offset;  // output cycle within the frame (0 = frame_tick)
    logic [7:0]  exp_dig;
    logic [7:0]  exp_seg;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    wr_en  = 1'b1;
    wr_sel = sel;
    wdata  = d;
    step();
    wr_en  = 1'b0;
  endtask

  // Advance at least one cycle and stop on the next frame_tick.
  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < FRAME + 40);
    if (!frame_tick) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no frame_tick within %0d cycles", name, n);
    end
  endtask

  initial begin
    int n;
    int lit;
    int ticks;

    vecs[0]  = '{8'hFF, 5'h0F, 8'h00, 32'h0000_1234,   0, 8'hFE, 8'h99};
    vecs[1]  = '{8'hFF, 5'h0F, 8'h00, 32'h0000_1234,  96, 8'hF7, 8'hF9};
    vecs[2]  = '{8'hFF, 5'h0F, 8'h80, 32'h89AB_CDEF, 229, 8'h7F, 8'h00};
    vecs[3]  = '{8'hFF, 5'h0F, 8'h00, 32'h89AB_CDEF,  33, 8'hFD, 8'h86};
    vecs[4]  = '{8'hFF, 5'h0F, 8'h00, 32'h89AB_CDEF, 170, 8'hDF, 8'h88};
    vecs[5]  = '{8'hFF, 5'h00, 8'h00, 32'h89AB_CDEF,   1, 8'hFE, 8'h8E};
    vecs[6]  = '{8'hFF, 5'h00, 8'h00, 32'h89AB_CDEF,   2, 8'hFF, 8'hFF};
    vecs[7]  = '{8'hFF, 5'h03, 8'h00, 32'h0000_0005,   7, 8'hFE, 8'h92};
    vecs[8]  = '{8'hFF, 5'h03, 8'h00, 32'h0000_0005,   8, 8'hFF, 8'hFF};
    vecs[9]  = '{8'hFF, 5'h1F, 8'h00, 32'h0000_0012,  32, 8'hFD, 8'hF9};
    vecs[10] = '{8'hFF, 5'h1F, 8'h00, 32'h0000_0012,  64, 8'hFF, 8'hFF};
    vecs[11] = '{8'hFF, 5'h1F, 8'h00, 32'h0000_0000,   0, 8'hFE, 8'hC0};
    vecs[12] = '{8'hFF, 5'h1F, 8'h00, 32'h0000_0000,  32, 8'hFF, 8'hFF};
    vecs[13] = '{8'hFF, 5'h1F, 8'h00, 32'h1000_0000,  96, 8'hF7, 8'hC0};
    vecs[14] = '{8'h00, 5'h0F, 8'h00, 32'h0000_1234,   0, 8'hFF, 8'hFF};
    vecs[15] = '{8'h04, 5'h0F, 8'h00, 32'h0000_1234,  64, 8'hFB, 8'hA4};
    vecs[16] = '{8'hFF, 5'h0F, 8'h01, 32'h0000_0000,   0, 8'hFE, 8'h40};

    rst_n  = 1'b0;
    wr_en  = 1'b0;
    wr_sel = 2'd0;
    wdata  = 32'h0;

    // Reset state, with a write attempted under reset.
    step();
    wr_en = 1'b1; wr_sel = 2'd0; wdata = 32'hFFFF_FFFF;
    step();
    wr_en = 1'b0;
    step();
    chk("rst_dig_en", {24'h0, dig_en}, 32'hFF);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    chk("rst_tick", {31'h0, frame_tick}, 32'h0);

    // First cycle after release: digit 0, phase 0.
    rst_n = 1'b1;
    step();                                   // t = 0
    chk("rel_dig_en", {24'h0, dig_en}, 32'hFE);
    chk("rel_seg", {24'h0, seg}, 32'hC0);
    chk("rel_tick", {31'h0, frame_tick}, 32'h1);

    // Buffered data write captured on cycle 50.
    repeat (49) step();                       // t = 49
    wr(2'd0, 32'h0000_1234);                  // t = 50
    repeat (50) step();                       // t = 100, digit 3
    chk("buf_pre_dig_en", {24'h0, dig_en}, 32'hF7);
    chk("buf_pre_seg", {24'h0, seg}, 32'hC0);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < FRAME + 40);
    chk("tick_period", n, 32'(FRAME - 100));
    chk("buf_d0_seg", {24'h0, seg}, 32'h99);
    repeat (32) step();
    chk("buf_d1_seg", {24'h0, seg}, 32'hB0);
    repeat (32) step();
    chk("buf_d2_seg", {24'h0, seg}, 32'hA4);
    repeat (32) step();
    chk("buf_d3_seg", {24'h0, seg}, 32'hF9);

    // Table of static configurations sampled at one frame offset each.
    for (int i = 0; i < 17; i++) begin
      wait_tick("vec_sync");
      wr(2'd1, {24'h0, vecs[i].mask});
      wr(2'd2, {27'h0, vecs[i].cfg});
      wr(2'd3, {24'h0, vecs[i].dp});
      wr(2'd0, vecs[i].data);
      wait_tick("vec_commit");
      repeat (vecs[i].offset) step();
      chk($sformatf("vec%0d_dig_en", i), {24'h0, dig_en}, {24'h0, vecs[i].exp_dig});
      chk($sformatf("vec%0d_seg", i), {24'h0, seg}, {24'h0, vecs[i].exp_seg});
      chk($sformatf("vec%0d_tick", i), {31'h0, frame_tick},
          (vecs[i].offset == 0) ? 32'h1 : 32'h0);
    end

    // Brightness 0: 2 lit cycles per 32-cycle slot, 16 per frame.
    wr(2'd1, 32'hFF);
    wr(2'd2, 32'h00);
    wait_tick("bright0_sync");
    lit = 0;
    n   = 0;
    for (int t = 0; t < FRAME; t++) begin
      if (dig_en != 8'hFF) begin
        lit++;
        if (t < 32) n++;
      end
      if (t != FRAME - 1) step();
    end
    chk("bright0_slot_lit", n, 32'd2);
    chk("bright0_frame_lit", lit, 32'd16);

    // Mask 00: dark for a whole frame while frame_tick keeps pulsing.
    wr(2'd2, 32'h0F);
    wr(2'd1, 32'h00);
    wait_tick("mask0_sync");
    lit   = 0;
    ticks = 0;
    for (int t = 0; t < FRAME; t++) begin
      if (dig_en != 8'hFF) lit++;
      if (frame_tick) ticks++;
      step();
    end
    chk("mask0_lit", lit, 32'd0);
    chk("mask0_ticks", ticks, 32'd1);
    chk("mask0_next_tick", {31'h0, frame_tick}, 32'h1);

    // Boundary-write race: write captured on the frame-end edge.
    wr(2'd1, 32'hFF);
    wr(2'd3, 32'h00);
    wr(2'd0, 32'h1111_1111);
    wait_tick("race_sync");                   // t = 0, shows 1s
    chk("race_base_seg", {24'h0, seg}, 32'hF9);
    repeat (FRAME - 2) step();                // t = 254
    wr(2'd0, 32'h2222_2222);                  // captured at edge producing t = 255
    step();                                   // next frame, t = 0
    chk("race_next_tick", {31'h0, frame_tick}, 32'h1);
    chk("race_next_seg", {24'h0, seg}, 32'hF9);
    repeat (FRAME) step();
    chk("race_after_tick", {31'h0, frame_tick}, 32'h1);
    chk("race_after_seg", {24'h0, seg}, 32'hA4);

    // Mid-frame reset clears data and restarts the frame.
    repeat (40) step();
    rst_n = 1'b0;
    step();
    chk("midrst_dig_en", {24'h0, dig_en}, 32'hFF);
    chk("midrst_seg", {24'h0, seg}, 32'hFF);
    chk("midrst_tick", {31'h0, frame_tick}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("midrel_dig_en", {24'h0, dig_en}, 32'hFE);
    chk("midrel_seg", {24'h0, seg}, 32'hC0);
    chk("midrel_tick", {31'h0, frame_tick}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter PHASE_LEN, default 1000: cpu_clk cycles per brightness phase; legal range >= 1.
REQ-002 SHALL have port cpu_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port wr_en, input, 1: register write strobe from the bus bridge.
REQ-005 SHALL have port wr_sel, input, 2: register select; 0=data, 1=digit mask, 2=config, 3=dp.
REQ-006 SHALL have port wdata, input, 32: write data.
REQ-007 SHALL have port dig_en, output, 8: active-low digit enables; bit i is digit i, and digit 7 is the most significant.
REQ-008 SHALL have port seg, output, 8: active-low segments as {dp,g,f,e,d,c,b,a}.
REQ-009 SHALL have port frame_tick, output, 1: one-cycle pulse marking the first cycle of each frame.

Function
REQ-010 SHALL hold the following counters: phase_cnt (0..PHASE_LEN-1), phase (0..15) and digit (0..7).
REQ-011 SHALL run the counters as follows: phase_cnt increments every cycle; at wrap, phase increments; at phase wrap, digit increments; digit 7 wraps to 0.
REQ-012 SHALL define the timing as: slot = 16*PHASE_LEN cycles per digit; frame = 8 slots = 128*PHASE_LEN cycles.
REQ-013 SHALL handle writes as follows:
- wr_sel=0 writes shadow_data[31:0].
- wr_sel=3 writes shadow_dp = wdata[7:0].
- wr_sel=1 writes mask = wdata[7:0] (1 = digit enabled).
- wr_sel=2 writes bright = wdata[3:0] and blank_lz = wdata[4].
- All writes take effect at the next edge.
REQ-014 SHALL commit shadow_data and shadow_dp into active_data and active_dp only on the frame-boundary edge (digit=7, phase=15, phase_cnt=PHASE_LEN-1), so a frame never shows a mixed update.
REQ-015 SHALL, when a write to sel 0/3 lands on the frame-boundary edge, commit the pre-write shadow value; the new value lands in shadow and commits at the next boundary.
REQ-016 SHALL apply mask, bright and blank_lz immediately to the next registered output; these registers are not buffered.
REQ-017 SHALL treat digit d as lit when:
- mask[d]=1, and
- phase <= bright, and
- d is not blanked.
REQ-018 SHALL treat digit d as blanked when blank_lz=1, d != 0, and active_data nibbles d..7 are all zero.
REQ-019 SHALL, when digit d is lit, drive dig_en = ~(1<<d), seg[6:0] = the active-low hex pattern of active_data[4d+3:4d], and seg[7] = ~active_dp[d].
REQ-020 SHALL, when digit d is not lit, drive dig_en = 8'hFF and seg = 8'hFF.
REQ-021 SHALL use the following active-low hex patterns (gfedcba):
- 0=40, 1=79, 2=24, 3=30
- 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03
- C=46, d=21, E=06, F=0E
REQ-022 SHALL register dig_en, seg and frame_tick, with one cycle of latency from the counter state they reflect.
REQ-023 SHALL drive dig_en as one-hot-low or all-ones; no other value is legal.
REQ-024 SHALL assert frame_tick for exactly one cycle per frame, in the cycle whose outputs show digit 0, phase 0, phase_cnt 0; it is independent of mask.
REQ-025 SHALL give bright=0 a 1/16 duty and bright=F a 16/16 duty; there is no zero-duty setting (use mask for off).

Reset
REQ-026 SHALL, on cpu_rst_n=0 at an edge, set:
- counters to 0;
- shadow_data, active_data, shadow_dp and active_dp to 0;
- mask to 8'hFF, bright to 4'hF and blank_lz to 0;
- dig_en to 8'hFF, seg to 8'hFF and frame_tick to 0.
REQ-027 SHALL let reset override a simultaneous wr_en; reset asserted mid-frame discards the shadow and the frame in progress.
REQ-028 SHALL output, in the first cycle after reset release, the registered view of digit 0, phase 0 (frame_tick=1).

Verification (PHASE_LEN=2: slot=32 cycles, frame=256 cycles)
REQ-029 SHALL cover reset release: in the first cycle after release, dig_en=FE, seg=C0 and frame_tick=1; frame_tick then recurs every 256 cycles.
REQ-030 SHALL cover the buffered data write: wr_sel=0 with 0x00001234 at cycle 50 leaves the display unchanged (seg=C0 on lit digits) until the next frame_tick; after it, digit0 seg=99, digit1 seg=B0, digit2 seg=A4, digit3 seg=F9.
REQ-031 SHALL cover brightness 0: bright=0 makes each digit low on dig_en for 2 cycles per 32-cycle slot, with dig_en=FF for the other 30.
REQ-032 SHALL cover leading-zero blanking: blank_lz=1 with data 0x00000012 makes digit0 and digit1 light, and digits 2..7 keep dig_en=FF during their slots; with data 0, only digit0 lights (seg=C0).
REQ-033 SHALL cover the boundary-write race: a data write on the frame-boundary edge is not shown in the following frame and is shown in the frame after it.
REQ-034 SHALL cover mask off and mid-frame reset:
- mask=00 gives dig_en=FF for a full frame with frame_tick still pulsing.
- cpu_rst_n low for 1 cycle mid-frame gives FF/FF outputs next cycle, and data reads back as cleared (digit0 seg=C0).
